exec_unit_mc: RTL
=================

EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal 8..64, power of 2).
REQ-002 SHALL have parameter PCW, default 32, PC width.
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operation valid.
REQ-006 SHALL have port in_ready  output  1  unit accepts operation this cycle.
REQ-007 SHALL have port in_op  input  4  opcode: 0 ADD, 1 SUB, 2 CMP, 3 MUL, 4 DIV, 5 MOD, 6 LSL, 7 LSR, 8 ASR, 9 OR, 10 AND, 11 NOT, 12 MOV, 13-15 NOP.
REQ-008 SHALL have ports in_a, in_b  input  XLEN each  operands.
REQ-009 SHALL have ports in_pc, in_br_pc  input  PCW each  instruction PC, precomputed branch target.
REQ-010 SHALL have port in_br  input  3  {isUBranch, isBgt, isBeq}.
REQ-011 SHALL have port flush  input  1  discard all in-flight work.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have ports out_result (XLEN), out_pc (PCW)  output  result and PC of the operation.
REQ-015 SHALL have ports br_taken (1), br_pc (PCW)  output  branch redirect to fetch.
REQ-016 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-017 SHALL accept an operation when in_valid && in_ready; in_ready = !flush && state==IDLE && (!out_valid || out_ready).
REQ-018 SHALL implement FSM IDLE, DIV, DONE: IDLE->DIV on accepting DIV/MOD; DIV->DONE after XLEN iterations; DONE->IDLE when the result is loaded into the output register.
REQ-019 SHALL load single-cycle ops (all except DIV/MOD) into the output register on the accepting edge: out_valid rises one cycle after acceptance.
REQ-020 SHALL compute DIV/MOD unsigned with a restoring divider, one quotient bit per cycle; out_valid rises XLEN+1 cycles after acceptance; busy is high in DIV and DONE.
REQ-021 SHALL hold out_valid and all out_* stable while out_valid && !out_ready; the DONE state waits there for a free output register.
REQ-022 SHALL truncate ADD/SUB/MUL to the low XLEN bits; shifts use in_b[log2(XLEN)-1:0]; ASR is sign-filling; NOT and MOV use in_b only; CMP and NOP produce result 0.
REQ-023 SHALL return quotient all-ones and remainder = in_a on divide by zero.
REQ-024 SHALL keep flags GT (signed in_a > in_b) and ET (in_a == in_b) in a register updated only on acceptance of CMP.
REQ-025 SHALL drive br_taken combinationally in the accepting cycle = isUBranch | (isBgt & GT) | (isBeq & ET), using the registered flags; br_pc = in_br_pc; both 0 when not accepting.
REQ-026 SHALL, on flush, clear out_valid, abort any division and return to IDLE on the next edge; flags are retained; no operation is accepted while flush is high.
REQ-027 SHALL let a simultaneous out_ready handshake and new acceptance replace the output register in the same cycle with no bubble.

Reset
REQ-028 SHALL, when Rst==0 at a clock edge, set state IDLE, out_valid 0, out_result 0, out_pc 0, GT 0, ET 0, divider registers 0, including mid-division (operation discarded).
REQ-029 SHALL drive in_ready 0, busy 0, br_taken 0 and br_pc 0 while Rst is low.

Configuration
REQ-030 SHALL compile the iterative divider only when macro EXEC_UNIT_DIV_EN is defined.
REQ-031 SHALL, without EXEC_UNIT_DIV_EN, treat DIV/MOD as single-cycle ops returning 0; the DIV and DONE states are unreachable and busy is constant 0.

Verification
REQ-032 SHALL cover: XLEN=32, ADD 0xFFFFFFFF+2, out_ready=1 -> out_valid one cycle later, out_result 0x00000001.
REQ-033 SHALL cover: DIV_EN, DIV 100/7 -> out_result 14 after 33 cycles; MOD 100/7 -> 2; DIV 5/0 -> 0xFFFFFFFF.
REQ-034 SHALL cover: CMP 5,3 then op with isBgt=1, in_br_pc=0x40 -> br_taken=1, br_pc=0x40; same with isBeq=1 -> br_taken=0.
REQ-035 SHALL cover: out_ready=0 for 4 cycles after ASR 0x80000000 by 4 -> out_result held at 0xF8000000, in_ready=0 throughout.
REQ-036 SHALL cover: flush 10 cycles into a DIV -> out_valid stays 0, busy=0 next cycle, next ADD completes normally.
REQ-037 SHALL cover: Rst=0 mid-division -> all outputs 0 the following cycle, first post-reset op accepted immediately.

Source files
------------

// File: rtl/exec_unit_mc.sv
// Execute unit: single-cycle ALU ops plus unsigned DIV/MOD (iterative divider built only with EXEC_UNIT_DIV_EN).
// Latency: 1 cycle for single-cycle ops, XLEN+1 cycles for DIV/MOD; branch redirect is combinational.
// Backpressure: one output register; in_ready drops while it is held or a division is in flight.
module exec_unit_mc #(
    parameter int XLEN = 32,
    parameter int PCW  = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [PCW-1:0]  in_pc,
    input  logic [PCW-1:0]  in_br_pc,
    input  logic [2:0]      in_br,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [PCW-1:0]  out_pc,
    output logic            br_taken,
    output logic [PCW-1:0]  br_pc,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_AND = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [PCW-1:0]  pc;
    } res_t;

    state_t          state, state_n;
    res_t            out_q, div_res;
    logic            out_valid_q;
    logic            gt_q, et_q;
    logic            out_free, accept, op_is_div, div_ld;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_y;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = Rst && !flush && (state == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    assign br_taken = accept && (in_br[2] || (in_br[1] && gt_q) || (in_br[0] && et_q));
    assign br_pc    = accept ? in_br_pc : '0;

    assign out_valid  = out_valid_q;
    assign out_result = out_q.result;
    assign out_pc     = out_q.pc;

    assign shamt = in_b[SHW-1:0];

    always_comb begin
        alu_y = '0;
        case (in_op)
            OP_ADD:         alu_y = in_a + in_b;
            OP_SUB:         alu_y = in_a - in_b;
            OP_MUL:         alu_y = in_a * in_b;
            OP_DIV, OP_MOD: alu_y = '0;
            OP_LSL:         alu_y = in_a << shamt;
            OP_LSR:         alu_y = in_a >> shamt;
            OP_ASR:         alu_y = $signed(in_a) >>> shamt;
            OP_OR:          alu_y = in_a | in_b;
            OP_AND:         alu_y = in_a & in_b;
            OP_NOT:         alu_y = ~in_b;
            OP_MOV:         alu_y = in_b;
            default:        alu_y = '0;
        endcase
    end

`ifdef EXEC_UNIT_DIV_EN
    localparam logic [SHW-1:0] LAST_ITER = SHW'(XLEN - 1);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [SHW-1:0]  cnt_q;
    logic            mod_q;
    logic [PCW-1:0]  dpc_q;
    logic [XLEN:0]   rem_sh, diff;

    assign op_is_div = (in_op == OP_DIV) || (in_op == OP_MOD);
    assign busy      = Rst && (state != S_IDLE);

    // Restoring step: shift in the next dividend bit, keep the difference if it did not go negative.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge Clk) begin
        if (!Rst || flush) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            mod_q <= 1'b0;
            dpc_q <= '0;
        end else if (accept && op_is_div) begin
            rem_q <= '0;
            quo_q <= in_a;
            dvs_q <= in_b;
            cnt_q <= '0;
            mod_q <= (in_op == OP_MOD);
            dpc_q <= in_pc;
        end else if (state == S_DIV) begin
            cnt_q <= cnt_q + 1'b1;
            if (diff[XLEN]) begin
                rem_q <= rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        div_res.result = mod_q ? rem_q : quo_q;
        div_res.pc     = dpc_q;
    end

    always_comb begin
        state_n = state;
        div_ld  = 1'b0;
        case (state)
            S_IDLE: if (accept && op_is_div) state_n = S_DIV;
            S_DIV:  if (cnt_q == LAST_ITER) state_n = S_DONE;
            S_DONE: begin
                if (out_free) begin
                    state_n = S_IDLE;
                    div_ld  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) begin
            state_n = S_IDLE;
            div_ld  = 1'b0;
        end
    end
`else
    // DIV/MOD fall through the ALU as single-cycle ops returning zero.
    assign op_is_div = 1'b0;
    assign busy      = 1'b0;

    always_comb begin
        div_res = '0;
        state_n = S_IDLE;
        div_ld  = 1'b0;
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            gt_q        <= 1'b0;
            et_q        <= 1'b0;
        end else begin
            if (accept && (in_op == OP_CMP)) begin
                gt_q <= $signed(in_a) > $signed(in_b);
                et_q <= (in_a == in_b);
            end
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept && !op_is_div) begin
                out_valid_q   <= 1'b1;
                out_q.result  <= alu_y;
                out_q.pc      <= in_pc;
            end else if (div_ld) begin
                out_valid_q <= 1'b1;
                out_q       <= div_res;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
